// File: rtl/sys_timing_gen.sv
// sys_timing_gen: H-count timing chain derived from clk100 through a
// programmable prescaler. Downstream logic runs on clk100 and qualifies
// itself with the per-tap rise/fall strobes instead of using derived clocks.
module sys_timing_gen #(
  parameter int HALF_PERIOD = 7,
  parameter int TAPS        = 9
) (
  input  logic            clk100,
  input  logic            rst_b,
  input  logic            hold,
  input  logic            load_en,
  input  logic [TAPS-1:0] load_val,
  output logic [TAPS-1:0] sc_h,
  output logic [TAPS-1:0] rise_en,
  output logic [TAPS-1:0] fall_en,
  output logic            wrap_tick
);

  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(HALF_PERIOD - 1);

  logic [PW-1:0]   pre;
  logic [TAPS-1:0] cnt;
  logic [TAPS-1:0] nxt;
  logic            adv;

  // The chain steps only at the end of a prescaler phase, and never while
  // held, loaded or in reset (keeps strobes quiet when HALF_PERIOD=1).
  assign adv = rst_b & (pre == PRE_LAST) & ~hold & ~load_en;
  assign nxt = cnt + 1'b1;

  // Prescaler and chain registers; load beats hold beats normal counting.
  always_ff @(posedge clk100 or negedge rst_b) begin
    if (!rst_b) begin
      pre <= '0;
      cnt <= '0;
    end else if (load_en) begin
      pre <= '0;
      cnt <= load_val;
    end else if (hold) begin
      pre <= pre;
      cnt <= cnt;
    end else if (adv) begin
      pre <= '0;
      cnt <= nxt;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Early strobes decoded from the registered state one cycle ahead of the
  // tap edges, so a flop enabled by them updates as the tap changes.
  always_comb begin
    rise_en   = '0;
    fall_en   = '0;
    wrap_tick = 1'b0;
    if (adv) begin
      rise_en   = ~cnt & nxt;
      fall_en   = cnt & ~nxt;
      wrap_tick = &cnt;
    end
  end

  assign sc_h = cnt;

endmodule
